// File: rtl/fdivsqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iter_ctrl
//
// Iteration controller for a radix-2 floating-point divide / square-root
// datapath that evaluates NCOPIES cascaded recurrence stages per cycle.
// It accepts an operation, sequences the recurrence for the number of
// cycles needed by the requested precision, then holds the result valid
// until the consumer takes it.
//
// Parameters
//   NCOPIES  recurrence stages evaluated per cycle (1..8)
//   CW       iteration counter width
//
// Ports
//   clk           clock, all state on rising edge
//   reset         asynchronous active-high reset
//   start         operation request, qualified by ready
//   ready         controller idle and able to accept
//   fmt           requested precision: 00 half, 01 single, 10 double, 11 quad
//   sqrt          request is square root (1) or divide (0)
//   special       special operand case, skip the recurrence entirely
//   flush         abort whatever is in progress
//   result_ready  consumer accepts the result
//   init          load the datapath initial registers this cycle
//   iter_en       enable the recurrence-stage registers this cycle
//   last          this is the final recurrence cycle
//   valid         result available
//   busy          operation in flight
//   sqrt_q        sqrt flag captured at accept
//   fmt_q         fmt captured at accept
// ---------------------------------------------------------------------------
module fdivsqrt_iter_ctrl #(
    parameter int NCOPIES = 4,
    parameter int CW      = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    input  logic [1:0]    fmt,
    input  logic          sqrt,
    input  logic          special,
    input  logic          flush,
    input  logic          result_ready,
    output logic          init,
    output logic          iter_en,
    output logic          last,
    output logic          valid,
    output logic          busy,
    output logic          sqrt_q,
    output logic [1:0]    fmt_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Recurrence bits are the fraction width plus three guard bits;
    // the same count serves divide and square root.
    localparam int N_H = (13  + NCOPIES - 1) / NCOPIES;
    localparam int N_S = (26  + NCOPIES - 1) / NCOPIES;
    localparam int N_D = (55  + NCOPIES - 1) / NCOPIES;
    localparam int N_Q = (115 + NCOPIES - 1) / NCOPIES;

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Counter load value: cycles to run minus one, so the counter reads
    // zero in the final recurrence cycle.
    function automatic logic [CW-1:0] iter_load(input logic [1:0] f);
        logic [CW-1:0] n;
        case (f)
            2'b00:   n = CW'(N_H - 1);
            2'b01:   n = CW'(N_S - 1);
            2'b10:   n = CW'(N_D - 1);
            2'b11:   n = CW'(N_Q - 1);
            default: n = CW'(N_Q - 1);
        endcase
        return n;
    endfunction

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          sqrt_q_r;
    logic [1:0]    fmt_q_r;
    logic          accept_s;

    assign ready    = (state_r == S_IDLE);
    assign busy     = (state_r == S_ITER) || (state_r == S_DONE);
    assign sqrt_q   = sqrt_q_r;
    assign fmt_q    = fmt_q_r;
    assign accept_s = start & ready & ~flush;

    // Datapath strobes decoded from the registered state; flush masks them.
    always_comb begin
        init    = 1'b0;
        iter_en = 1'b0;
        last    = 1'b0;
        valid   = 1'b0;
        if (flush) begin
            init    = 1'b0;
            iter_en = 1'b0;
            last    = 1'b0;
            valid   = 1'b0;
        end else begin
            init    = accept_s;
            iter_en = (state_r == S_ITER);
            last    = (state_r == S_ITER) && (cnt_r == CNT_ZERO);
            valid   = (state_r == S_DONE);
        end
    end

    // Controller FSM with iteration counter and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= CNT_ZERO;
            sqrt_q_r <= 1'b0;
            fmt_q_r  <= 2'b00;
        end else if (flush) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        sqrt_q_r <= sqrt;
                        fmt_q_r  <= fmt;
                        if (special) begin
                            state_r <= S_DONE;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            state_r <= S_ITER;
                            cnt_r   <= iter_load(fmt);
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ITER: begin
                    // The counter only moves down while nonzero, so it never wraps.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for fdivsqrt_iter_ctrl. Instance u_dut0 uses
// NCOPIES=4, u_dut1 uses NCOPIES=1 (own start line, other inputs shared).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle 0 is the cycle in which start is accepted.
// ---------------------------------------------------------------------------
module tb_fdivsqrt_iter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] fmt = 2'b00;
    logic       sqrt = 1'b0;
    logic       special = 1'b0;
    logic       flush = 1'b0;
    logic       result_ready = 1'b0;

    logic       ready0, init0, iter_en0, last0, valid0, busy0, sqrt_q0;
    logic [1:0] fmt_q0;
    logic       ready1, init1, iter_en1, last1, valid1, busy1, sqrt_q1;
    logic [1:0] fmt_q1;

    always #5 clk = ~clk;

    fdivsqrt_iter_ctrl #(.NCOPIES(4), .CW(7)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .ready(ready0),
        .fmt(fmt), .sqrt(sqrt), .special(special), .flush(flush),
        .result_ready(result_ready), .init(init0), .iter_en(iter_en0),
        .last(last0), .valid(valid0), .busy(busy0), .sqrt_q(sqrt_q0),
        .fmt_q(fmt_q0)
    );

    fdivsqrt_iter_ctrl #(.NCOPIES(1), .CW(7)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .ready(ready1),
        .fmt(fmt), .sqrt(sqrt), .special(special), .flush(flush),
        .result_ready(result_ready), .init(init1), .iter_en(iter_en1),
        .last(last1), .valid(valid1), .busy(busy1), .sqrt_q(sqrt_q1),
        .fmt_q(fmt_q1)
    );

    // Outputs of the instance currently under test.
    logic       sel = 1'b0;
    wire        m_ready   = sel ? ready1   : ready0;
    wire        m_init    = sel ? init1    : init0;
    wire        m_iter_en = sel ? iter_en1 : iter_en0;
    wire        m_last    = sel ? last1    : last0;
    wire        m_valid   = sel ? valid1   : valid0;
    wire        m_busy    = sel ? busy1    : busy0;
    wire        m_sqrt_q  = sel ? sqrt_q1  : sqrt_q0;
    wire [1:0]  m_fmt_q   = sel ? fmt_q1   : fmt_q0;

    int nvec = 0;
    int nerr = 0;

    // Operation measurement results.
    int r_init0, r_iter, r_first_iter, r_last_cyc, r_nlast;
    int r_valid_first, r_valid_cnt, r_ready_cyc, r_overlap, r_stable_err, r_done;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation and trace it until ready returns after valid.
    // result_ready rises once valid has been seen for more than 'hold' cycles.
    task automatic run_op(input logic which, input logic [1:0] f, input logic s,
                          input logic sp, input int hold, input int budget);
        @(posedge clk); #1;
        sel = which; fmt = f; sqrt = s; special = sp; result_ready = 1'b0;
        if (which) start1 = 1'b1; else start = 1'b1;
        @(negedge clk);
        r_init0 = int'(m_init);
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0;
        r_iter = 0; r_first_iter = -1; r_last_cyc = -1; r_nlast = 0;
        r_valid_first = -1; r_valid_cnt = 0; r_ready_cyc = -1;
        r_overlap = 0; r_stable_err = 0; r_done = 0;
        for (int c = 1; c <= budget && r_done == 0; c++) begin
            @(negedge clk);
            if (m_iter_en) begin
                r_iter++;
                if (r_first_iter < 0) r_first_iter = c;
            end
            if (m_last) begin
                r_nlast++;
                r_last_cyc = c;
            end
            if (m_valid && m_ready) r_overlap++;
            if (m_busy && (m_fmt_q !== f || m_sqrt_q !== s)) r_stable_err++;
            if (m_valid) begin
                r_valid_cnt++;
                if (r_valid_first < 0) r_valid_first = c;
                result_ready = (r_valid_cnt > hold);
            end else begin
                result_ready = 1'b0;
            end
            if (m_ready && r_valid_cnt > 0) begin
                r_ready_cyc = c;
                r_done = 1;
            end
            if (r_done == 0) begin
                @(posedge clk); #1;
            end
        end
        result_ready = 1'b0;
        chk("op_timeout", r_done, 1);
    endtask

    initial begin
        int vcount;
        int icount;
        int vfirst;

        // Reset state, checked while reset is held and after release.
        sel = 1'b0;
        #12;
        chk("rst_ready", int'(ready0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_iter_en", int'(iter_en0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_last", int'(last0), 0);
        chk("rst_init", int'(init0), 0);
        chk("rst_sqrt_q", int'(sqrt_q0), 0);
        chk("rst_fmt_q", int'(fmt_q0), 0);
        @(negedge clk);
        reset = 1'b0;

        // Single divide, NCOPIES=4: N = ceil(26/4) = 7.
        run_op(1'b0, 2'b01, 1'b0, 1'b0, 0, 40);
        chk("s_init0", r_init0, 1);
        chk("s_iter_cnt", r_iter, 7);
        chk("s_first_iter", r_first_iter, 1);
        chk("s_last_cyc", r_last_cyc, 7);
        chk("s_nlast", r_nlast, 1);
        chk("s_valid_cyc", r_valid_first, 8);
        chk("s_valid_cnt", r_valid_cnt, 1);
        chk("s_ready_cyc", r_ready_cyc, 9);
        chk("s_overlap", r_overlap, 0);
        chk("s_stable", r_stable_err, 0);

        // Quad sqrt with result held off 3 cycles: N = ceil(115/4) = 29.
        run_op(1'b0, 2'b11, 1'b1, 1'b0, 3, 60);
        chk("q_iter_cnt", r_iter, 29);
        chk("q_last_cyc", r_last_cyc, 29);
        chk("q_valid_cyc", r_valid_first, 30);
        chk("q_valid_cnt", r_valid_cnt, 4);
        chk("q_ready_cyc", r_ready_cyc, 34);
        chk("q_overlap", r_overlap, 0);
        chk("q_stable", r_stable_err, 0);

        // Double special: no recurrence, valid next cycle.
        run_op(1'b0, 2'b10, 1'b0, 1'b1, 0, 20);
        chk("sp_init0", r_init0, 1);
        chk("sp_iter_cnt", r_iter, 0);
        chk("sp_nlast", r_nlast, 0);
        chk("sp_valid_cyc", r_valid_first, 1);
        chk("sp_ready_cyc", r_ready_cyc, 2);

        // Half divide and single sqrt: N = 4 and 7 (sqrt does not change N).
        run_op(1'b0, 2'b00, 1'b0, 1'b0, 0, 20);
        chk("h_iter_cnt", r_iter, 4);
        chk("h_valid_cyc", r_valid_first, 5);
        run_op(1'b0, 2'b01, 1'b1, 1'b0, 1, 20);
        chk("ssq_iter_cnt", r_iter, 7);
        chk("ssq_valid_cnt", r_valid_cnt, 2);
        chk("ssq_stable", r_stable_err, 0);

        // NCOPIES=1 half: N = 13.
        run_op(1'b1, 2'b00, 1'b0, 1'b0, 0, 40);
        chk("n1_iter_cnt", r_iter, 13);
        chk("n1_first_iter", r_first_iter, 1);
        chk("n1_last_cyc", r_last_cyc, 13);
        chk("n1_valid_cyc", r_valid_first, 14);
        sel = 1'b0;

        // Flush together with start in IDLE: nothing is accepted.
        @(posedge clk); #1;
        fmt = 2'b10; sqrt = 1'b0; special = 1'b0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("fi_init", int'(init0), 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("fi_busy", int'(busy0), 0);

        // Flush in the 5th ITER cycle of a double divide.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("fl_iter_c4", int'(iter_en0), 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_iter_c5", int'(iter_en0), 0);
        chk("fl_valid_c5", int'(valid0), 0);
        chk("fl_last_c5", int'(last0), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        chk("fl_ready_c6", int'(ready0), 1);
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid0) vcount++;
        end
        chk("fl_no_valid", vcount, 0);
        result_ready = 1'b0;

        // Asynchronous reset mid-ITER of a single sqrt.
        @(posedge clk); #1;
        fmt = 2'b01; sqrt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_ready", int'(ready0), 1);
        chk("ar_busy", int'(busy0), 0);
        chk("ar_iter_en", int'(iter_en0), 0);
        chk("ar_valid", int'(valid0), 0);
        chk("ar_last", int'(last0), 0);
        chk("ar_sqrt_q", int'(sqrt_q0), 0);
        chk("ar_fmt_q", int'(fmt_q0), 0);
        @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid0) vcount++;
        end
        chk("ar_no_valid", vcount, 0);

        // Start while busy is ignored: double divide keeps fmt_q=10, N=14.
        @(posedge clk); #1;
        fmt = 2'b10; sqrt = 1'b0; start = 1'b1; result_ready = 1'b1;
        icount = 0; vfirst = -1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            start = (c >= 3 && c <= 5);
            fmt = 2'b11; sqrt = 1'b1;
            @(negedge clk);
            if (iter_en0) icount++;
            if (valid0 && vfirst < 0) vfirst = c;
            if (c == 10) begin
                chk("ib_fmt_q", int'(fmt_q0), 2);
                chk("ib_sqrt_q", int'(sqrt_q0), 0);
            end
        end
        chk("ib_iter_cnt", icount, 14);
        chk("ib_valid_cyc", vfirst, 15);
        chk("ib_end_ready", int'(ready0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fdivsqrt_iter_ctrl.md
FDIVSQRT_ITER_CTRL -- requirements
Module: fdivsqrt_iter_ctrl

Interface
REQ-001 SHALL have parameter NCOPIES, 4, number of cascaded radix-2 recurrence stages evaluated per cycle (1..8).
REQ-002 SHALL have parameter CW, 7, iteration counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request; qualified by ready.
REQ-006 SHALL have port ready  output  1  controller can accept an operation.
REQ-007 SHALL have port fmt  input  2  precision of request: 00 half, 01 single, 10 double, 11 quad.
REQ-008 SHALL have port sqrt  input  1  request is square root (1) or divide (0).
REQ-009 SHALL have port special  input  1  request is a special case (NaN/Inf/zero operand); no iteration needed.
REQ-010 SHALL have port flush  input  1  abort any operation in progress.
REQ-011 SHALL have port result_ready  input  1  consumer accepts result.
REQ-012 SHALL have port init  output  1  load initial residual/divisor/U/UM/C registers this cycle.
REQ-013 SHALL have port iter_en  output  1  enable recurrence-stage registers this cycle.
REQ-014 SHALL have port last  output  1  current iteration is the final one.
REQ-015 SHALL have port valid  output  1  result available.
REQ-016 SHALL have port busy  output  1  operation in flight (ITER or DONE).
REQ-017 SHALL have port sqrt_q  output  1  latched sqrt flag; drives the stage SqrtE select for the whole operation.
REQ-018 SHALL have port fmt_q  output  2  latched fmt for postprocessing.

Function
REQ-019 SHALL implement states IDLE, ITER, DONE, encoded in one state register.
REQ-020 Accept SHALL occur when start & ready & ~flush; ready SHALL equal (state==IDLE).
REQ-021 On accept, init SHALL be 1 combinationally in that cycle; sqrt_q and fmt_q SHALL load sqrt and fmt at the clock edge.
REQ-022 Iteration bits SHALL be Nf+3 with Nf = 10, 23, 52, 112 for fmt 00, 01, 10, 11; cycle count N = ceil((Nf+3)/NCOPIES), computed as a constant table, sqrt does not alter N.
REQ-023 On accept with special=0, next state SHALL be ITER and counter SHALL load N-1.
REQ-024 On accept with special=1, next state SHALL be DONE directly; iter_en SHALL never assert for that operation.
REQ-025 In ITER, iter_en SHALL be 1 every cycle and the counter SHALL decrement by 1 per cycle.
REQ-026 In ITER with counter==0, last SHALL be 1 and next state SHALL be DONE; last SHALL be 0 in all other cycles.
REQ-027 Non-special latency SHALL be: accept at cycle 0, iter_en in cycles 1..N, valid first high in cycle N+1.
REQ-028 In DONE, valid SHALL be 1 and held with sqrt_q/fmt_q stable until result_ready=1; then next state SHALL be IDLE.
REQ-029 A new start SHALL NOT be accepted in the same cycle DONE retires (ready low in DONE); earliest next accept is one cycle later.
REQ-030 start while not ready SHALL be ignored with no effect on state, counter or latched fields.
REQ-031 flush=1 in any state SHALL force next state IDLE, suppress init/iter_en/last/valid in that cycle, and take priority over start and result_ready.
REQ-032 busy SHALL equal (state==ITER) | (state==DONE).
REQ-033 Counter SHALL never wrap: it is loaded only on accept and decremented only in ITER while nonzero.

Reset
REQ-034 reset=1 SHALL asynchronously set state IDLE, counter 0, sqrt_q 0, fmt_q 00; outputs then ready=1, init=0, iter_en=0, last=0, valid=0, busy=0.
REQ-035 reset asserted mid-operation SHALL abandon it; no valid SHALL appear after reset deasserts until a new accept.

Verification
REQ-036 NCOPIES=4, start fmt=01 sqrt=0 special=0 at cycle 0 -> init=1 cycle 0, iter_en cycles 1..7, last cycle 7, valid cycle 8, sqrt_q=0.
REQ-037 NCOPIES=4, fmt=11 sqrt=1, result_ready held 0 for 3 cycles after valid -> 29 iter_en cycles, valid held 4 cycles, sqrt_q=1, fmt_q=11 throughout, IDLE after handshake.
REQ-038 start fmt=10 special=1 at cycle 0 -> valid cycle 1, iter_en never 1, ready returns cycle 2 with result_ready=1.
REQ-039 flush=1 in 5th ITER cycle of a fmt=10 op -> iter_en 0 that cycle, ready=1 next cycle, valid never asserts.
REQ-040 reset pulsed asynchronously mid-ITER -> state IDLE immediately, all outputs at reset values, start during busy ignored (fmt_q unchanged).
REQ-041 NCOPIES=1, fmt=00 -> N=13: iter_en cycles 1..13, valid cycle 14.
